// File: rtl/jogo_sequencia_pkg.sv
// State encodings and defaults for the sequence-game control unit.
// Shared by the controller, the debug 7-segment decoder and the bench.
package jogo_sequencia_pkg;

    localparam int TIMEOUT_CYCLES_DEFAULT = 5000;

    localparam logic [3:0] ST_INICIAL        = 4'h0;
    localparam logic [3:0] ST_PREPARACAO     = 4'h1;
    localparam logic [3:0] ST_INICIA_RODADA  = 4'h2;
    localparam logic [3:0] ST_ESPERA_JOGADA  = 4'h4;
    localparam logic [3:0] ST_REGISTRA       = 4'h5;
    localparam logic [3:0] ST_COMPARA        = 4'h6;
    localparam logic [3:0] ST_PROXIMA_JOGADA = 4'h7;
    localparam logic [3:0] ST_PROXIMA_RODADA = 4'h8;
    localparam logic [3:0] ST_FIM_TIMEOUT    = 4'hD;
    localparam logic [3:0] ST_ERRO           = 4'hE;
    localparam logic [3:0] ST_ACERTO         = 4'hF;

    typedef enum logic [3:0] {
        INICIAL        = ST_INICIAL,
        PREPARACAO     = ST_PREPARACAO,
        INICIA_RODADA  = ST_INICIA_RODADA,
        ESPERA_JOGADA  = ST_ESPERA_JOGADA,
        REGISTRA       = ST_REGISTRA,
        COMPARA        = ST_COMPARA,
        PROXIMA_JOGADA = ST_PROXIMA_JOGADA,
        PROXIMA_RODADA = ST_PROXIMA_RODADA,
        FIM_TIMEOUT    = ST_FIM_TIMEOUT,
        ERRO           = ST_ERRO,
        ACERTO         = ST_ACERTO
    } estado_t;

endpackage

// File: rtl/jogo_sequencia_unidade_controle_if.sv
// Control/status bundle between the game top level, the datapath and the control unit.
// slave = control unit; master = the side that drives moves/comparator flags.
interface jogo_sequencia_unidade_controle_if;

    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       fimL;
    logic       enderecoIgualLimite;
    logic       zeraC;
    logic       contaC;
    logic       zeraL;
    logic       contaL;
    logic       zeraR;
    logic       registraR;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic       pronto;
    logic [3:0] db_estado;

    modport master (
        output iniciar, jogada, igual, fimL, enderecoIgualLimite,
        input  zeraC, contaC, zeraL, contaL, zeraR, registraR,
        input  acertou, errou, timeout, pronto, db_estado
    );

    modport slave (
        input  iniciar, jogada, igual, fimL, enderecoIgualLimite,
        output zeraC, contaC, zeraL, contaL, zeraR, registraR,
        output acertou, errou, timeout, pronto, db_estado
    );

endinterface

// File: rtl/jogo_sequencia_unidade_controle_contador_timeout.sv
// Idle-player timer: counts cycles while enabled, saturates at TIMEOUT_CYCLES-1 (expirou, combinational).
// Used only when JOGO_TIMEOUT_EN is defined; clear has priority over enable; no backpressure.
module contador_timeout #(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expirou
);

    localparam int            TW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LIMITE = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] contagem;

    // Saturating so a stalled FSM can never see the count wrap back to zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem <= '0;
        end else if (clear) begin
            contagem <= '0;
        end else if (enable && contagem != LIMITE) begin
            contagem <= contagem + TW'(1);
        end
    end

    assign expirou = (contagem == LIMITE);

endmodule

// File: rtl/jogo_sequencia_unidade_controle.sv
// Moore control unit for the sequence-memory game; outputs decode the current state, 1-cycle state latency.
// No backpressure: jogada/iniciar outside their accepting states are dropped. JOGO_TIMEOUT_EN enables the idle timer.
module jogo_sequencia_unidade_controle
    import jogo_sequencia_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input logic                              clock,
    input logic                              reset,
    jogo_sequencia_unidade_controle_if.slave bus
);

    estado_t estado;
    estado_t proximo;

`ifdef JOGO_TIMEOUT_EN
    logic expirou;

    contador_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_contador_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (estado != ESPERA_JOGADA),
        .enable  (estado == ESPERA_JOGADA),
        .expirou (expirou)
    );
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL:        proximo = bus.iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     proximo = INICIA_RODADA;
            INICIA_RODADA:  proximo = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                // A move arriving in the expiry cycle still counts.
                if (bus.jogada) begin
                    proximo = REGISTRA;
`ifdef JOGO_TIMEOUT_EN
                end else if (expirou) begin
                    proximo = FIM_TIMEOUT;
`endif
                end else begin
                    proximo = ESPERA_JOGADA;
                end
            end
            REGISTRA:       proximo = COMPARA;
            COMPARA: begin
                if (!bus.igual) begin
                    proximo = ERRO;
                end else if (!bus.enderecoIgualLimite) begin
                    proximo = PROXIMA_JOGADA;
                end else if (!bus.fimL) begin
                    proximo = PROXIMA_RODADA;
                end else begin
                    proximo = ACERTO;
                end
            end
            PROXIMA_JOGADA: proximo = ESPERA_JOGADA;
            PROXIMA_RODADA: proximo = INICIA_RODADA;
`ifdef JOGO_TIMEOUT_EN
            FIM_TIMEOUT,
`endif
            ERRO,
            ACERTO:         proximo = bus.iniciar ? PREPARACAO : estado;
            default:        proximo = INICIAL;
        endcase
    end

    assign bus.zeraC     = (estado == INICIAL) || (estado == PREPARACAO) || (estado == INICIA_RODADA);
    assign bus.zeraL     = (estado == INICIAL) || (estado == PREPARACAO);
    assign bus.zeraR     = (estado == INICIAL) || (estado == PREPARACAO);
    assign bus.contaC    = (estado == PROXIMA_JOGADA);
    assign bus.contaL    = (estado == PROXIMA_RODADA);
    assign bus.registraR = (estado == REGISTRA);
    assign bus.acertou   = (estado == ACERTO);
    assign bus.errou     = (estado == ERRO);
`ifdef JOGO_TIMEOUT_EN
    assign bus.timeout   = (estado == FIM_TIMEOUT);
`else
    assign bus.timeout   = 1'b0;
`endif
    assign bus.pronto    = bus.acertou || bus.errou || bus.timeout;
    assign bus.db_estado = estado;

endmodule

// File: tb/tb_jogo_sequencia_unidade_controle.sv
// Bench for the sequence-game control unit: directed game scenarios plus random play,
// predicted by a latency/event model and checked by a negedge scoreboard monitor.
`timescale 1ns/1ps
module tb_jogo_sequencia_unidade_controle;
    import jogo_sequencia_pkg::*;

    localparam int T = 8;
`ifdef JOGO_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    jogo_sequencia_unidade_controle_if bus ();

    jogo_sequencia_unidade_controle #(
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int         checks   = 0;
    int         errors   = 0;
    int         n_contaC = 0;
    int         n_contaL = 0;
    logic [3:0] sb[$];
    logic [3:0] plan[$];
    logic [3:0] cur      = ST_INICIAL;
    int         waited   = 0;

    // Expected {zeraC,contaC,zeraL,contaL,zeraR,registraR,acertou,errou,timeout,pronto}.
    function automatic logic [9:0] outs_for(input logic [3:0] c);
        logic [9:0] v;
        v = '0;
        case (c)
            ST_INICIAL, ST_PREPARACAO: v = 10'b1010100000;
            ST_INICIA_RODADA:          v = 10'b1000000000;
            ST_PROXIMA_JOGADA:         v = 10'b0100000000;
            ST_PROXIMA_RODADA:         v = 10'b0001000000;
            ST_REGISTRA:               v = 10'b0000010000;
            ST_ACERTO:                 v = 10'b0000001001;
            ST_ERRO:                   v = 10'b0000000101;
            ST_FIM_TIMEOUT:            v = 10'b0000000011;
            default:                   v = '0;
        endcase
        return v;
    endfunction

    initial begin : monitor
        logic [3:0] e;
        logic [9:0] got;
        logic [9:0] want;
        forever begin
            @(negedge clock or negedge reset);
            #1;
            if (sb.size() != 0) begin
                e    = sb.pop_front();
                want = outs_for(e);
                got  = {bus.zeraC, bus.contaC, bus.zeraL, bus.contaL, bus.zeraR,
                        bus.registraR, bus.acertou, bus.errou, bus.timeout, bus.pronto};
                checks++;
                if (bus.db_estado !== e) begin
                    errors++;
                    $display("FAIL db_estado @%0t: got %h expected %h", $time, bus.db_estado, e);
                end
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL outputs(state %h) @%0t: got %b expected %b", e, $time, got, want);
                end
                n_contaC += int'(bus.contaC);
                n_contaL += int'(bus.contaL);
            end
        end
    end

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One clock of stimulus; the model predicts the code visible after the edge.
    task automatic step(input logic ini, input logic jog, input logic ig,
                        input logic eil, input logic fl);
        logic [3:0] nxt;
        bus.iniciar             = ini;
        bus.jogada              = jog;
        bus.igual               = ig;
        bus.enderecoIgualLimite = eil;
        bus.fimL                = fl;
        if (plan.size() != 0) begin
            nxt = plan.pop_front();
        end else if (cur == ST_ESPERA_JOGADA) begin
            if (jog) begin
                nxt = ST_REGISTRA;
                plan.push_back(ST_COMPARA);
            end else if (TO_EN && waited + 1 == T) begin
                nxt = ST_FIM_TIMEOUT;
            end else begin
                nxt = ST_ESPERA_JOGADA;
            end
        end else if (cur == ST_COMPARA) begin
            if (!ig) begin
                nxt = ST_ERRO;
            end else if (!eil) begin
                nxt = ST_PROXIMA_JOGADA;
                plan.push_back(ST_ESPERA_JOGADA);
            end else if (!fl) begin
                nxt = ST_PROXIMA_RODADA;
                plan.push_back(ST_INICIA_RODADA);
                plan.push_back(ST_ESPERA_JOGADA);
            end else begin
                nxt = ST_ACERTO;
            end
        end else if (ini) begin
            nxt = ST_PREPARACAO;
            plan.push_back(ST_INICIA_RODADA);
            plan.push_back(ST_ESPERA_JOGADA);
        end else begin
            nxt = cur;
        end
        waited = (cur == ST_ESPERA_JOGADA && nxt == ST_ESPERA_JOGADA) ? waited + 1 : 0;
        cur    = nxt;
        @(posedge clock);
        #1;
        sb.push_back(cur);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        #2;
        bus.iniciar             = 1'b0;
        bus.jogada              = 1'b0;
        bus.igual               = 1'b0;
        bus.enderecoIgualLimite = 1'b0;
        bus.fimL                = 1'b0;
        cur    = ST_INICIAL;
        waited = 0;
        plan.delete();
        sb.push_back(ST_INICIAL);
        reset = 1'b0;
        @(posedge clock);
        #1;
        sb.push_back(ST_INICIAL);
        @(negedge clock);
        #2;
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic start();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic move(input int idle, input logic ig, input logic eil, input logic fl);
        repeat (idle) step(1'b0, 1'b0, ig, eil, fl);
        step(1'b0, 1'b1, ig, eil, fl);
        step(1'b0, 1'b0, ig, eil, fl);
        step(1'b0, 1'b0, ig, eil, fl);
    endtask

    initial begin
        #3;
        apply_reset();

        // Two-round win.
        n_contaC = 0;
        n_contaL = 0;
        start();
        move(1, 1'b1, 1'b1, 1'b0);
        move(2, 1'b1, 1'b0, 1'b0);
        move(0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        #2;
        check_int("contaL_pulses_win", n_contaL, 1);
        check_int("contaC_pulses_win", n_contaC, 1);

        // Wrong move, then restart from erro.
        start();
        move(0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Idle player.
        repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Move exactly in the expiry cycle.
        apply_reset();
        start();
        move(T - 1, 1'b1, 1'b0, 1'b0);

        // Reset in compara.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        apply_reset();

        // Long idle hold.
        start();
        repeat (TO_EN ? 20 : 10000) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random play.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) apply_reset();
            step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 5) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0);
        end

        @(negedge clock);
        #2;
        check_int("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
